avalon_pio_bank: RTL and testbench

Parametrised bank of CHANNELS Avalon-MM output ports, each WIDTH bits wide, for the Pong game-state registers (paddle/ball coordinates, score). It replaces per-signal single-register PIO slaves with one slave. Each channel has a CPU-written shadow register and a live register that drives the fabric. In frame-synchronous mode, all pending channels commit together on the rising edge of the video frame sync, so the renderer never sees a half-updated ball or paddle position.

---
 rtl/avalon_pio_bank_pkg.sv | 17 +
 rtl/pio_channel.sv | 70 +++++++
 rtl/avalon_pio_bank.sv | 108 ++++++++++
 tb/tb_avalon_pio_bank.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pio_bank_pkg.sv
// Shared constants for the Avalon-MM PIO bank: per-channel register offsets
// and the position of the pending flag in the SHADOW read image.
package avalon_pio_bank_pkg;

    localparam logic [1:0] REG_SHADOW  = 2'd0;
    localparam logic [1:0] REG_LIVE    = 2'd1;
    localparam logic [1:0] REG_SET     = 2'd2;
    localparam logic [1:0] REG_CLEAR   = 2'd3;

    localparam int         PENDING_BIT = 31;

    // True for the offsets that modify the shadow register.
    function automatic logic is_shadow_op(input logic [1:0] reg_sel);
        return reg_sel != REG_LIVE;
    endfunction

endpackage

// File: rtl/pio_channel.sv
// One output channel: CPU-written shadow register, fabric-facing live register
// and the pending flag that marks a shadow update not yet committed.
module pio_channel
    import avalon_pio_bank_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               COMMIT_MODE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_reg,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             tick,
    output logic [WIDTH-1:0] shadow,
    output logic [WIDTH-1:0] live,
    output logic             pending,
    output logic             commit
);

    logic             wr_valid;
    logic [WIDTH-1:0] next_shadow;

    assign wr_valid = wr_en && is_shadow_op(wr_reg);

    // A commit uses the shadow value held before any same-cycle write.
    assign commit = (COMMIT_MODE != 0) && tick && pending;

    // Shadow value produced by the write operation selected by the offset.
    always_comb begin
        next_shadow = shadow;
        case (wr_reg)
            REG_SHADOW: next_shadow = wr_data;
            REG_SET:    next_shadow = shadow | wr_data;
            REG_CLEAR:  next_shadow = shadow & ~wr_data;
            default:    next_shadow = shadow;
        endcase
    end

    // Shadow, live and pending registers; a same-cycle write wins over the
    // commit's pending clear so that the new value waits for the next frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow  <= RESET_VALUE;
            live    <= RESET_VALUE;
            pending <= 1'b0;
        end else begin
            if (wr_valid) begin
                shadow <= next_shadow;
            end
            if (COMMIT_MODE == 0) begin
                if (wr_valid) begin
                    live <= next_shadow;
                end
                pending <= 1'b0;
            end else begin
                if (commit) begin
                    live <= shadow;
                end
                if (wr_valid) begin
                    pending <= 1'b1;
                end else if (commit) begin
                    pending <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/avalon_pio_bank.sv
// Avalon-MM slave exposing CHANNELS output ports. Holds the address decode,
// the frame_sync rising-edge detector, the zero-latency read mux and the
// registered commit_pulse.
module avalon_pio_bank
    import avalon_pio_bank_pkg::*;
#(
    parameter int               CHANNELS    = 4,
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               COMMIT_MODE = 1,
    parameter int               ADDR_W      = $clog2(CHANNELS) + 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_W-1:0]         address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    input  logic                      frame_sync,
    output logic [CHANNELS*WIDTH-1:0] out_port,
    output logic                      commit_pulse
);

    logic                 wr_cycle;
    logic [1:0]           reg_sel;
    logic [31:0]          ch_idx;
    logic                 fs_prev;
    logic                 tick;
    logic [WIDTH-1:0]     shadow_a [CHANNELS];
    logic [WIDTH-1:0]     live_a   [CHANNELS];
    logic [CHANNELS-1:0]  pending_v;
    logic [CHANNELS-1:0]  commit_v;
    logic                 unused_wd;

    assign wr_cycle  = chipselect && !write_n;
    assign reg_sel   = address[1:0];
    assign unused_wd = &{1'b0, writedata[31:WIDTH]};

    // With a single channel there is no channel field in the address.
    generate
        if (ADDR_W > 2) begin : g_ch_field
            assign ch_idx = 32'(address[ADDR_W-1:2]);
        end else begin : g_no_ch_field
            assign ch_idx = '0;
        end
    endgenerate

    // Previous frame_sync sample; resets high so a sync already high at
    // reset exit is not mistaken for a new frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fs_prev <= 1'b1;
        end else begin
            fs_prev <= frame_sync;
        end
    end

    assign tick = frame_sync && !fs_prev;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            pio_channel #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE),
                .COMMIT_MODE (COMMIT_MODE)
            ) u_channel (
                .clk     (clk),
                .reset_n (reset_n),
                .wr_en   (wr_cycle && (ch_idx == 32'(c))),
                .wr_reg  (reg_sel),
                .wr_data (writedata[WIDTH-1:0]),
                .tick    (tick),
                .shadow  (shadow_a[c]),
                .live    (live_a[c]),
                .pending (pending_v[c]),
                .commit  (commit_v[c])
            );
            assign out_port[c*WIDTH +: WIDTH] = live_a[c];
        end
    endgenerate

    // Read mux; SET and CLEAR read back the same image as SHADOW, and
    // channel indices beyond the bank read as zero.
    always_comb begin
        readdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_idx == 32'(c)) begin
                if (reg_sel == REG_LIVE) begin
                    readdata[WIDTH-1:0] = live_a[c];
                end else begin
                    readdata[WIDTH-1:0]   = shadow_a[c];
                    readdata[PENDING_BIT] = pending_v[c];
                end
            end
        end
    end

    // One-cycle pulse in the cycle after a frame commit moved any channel.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            commit_pulse <= 1'b0;
        end else begin
            commit_pulse <= |commit_v;
        end
    end

endmodule

// File: tb/tb_avalon_pio_bank.sv
// Directed bench: a frame-commit bank (A) driven from a vector table plus a
// mid-frame reset sequence, and an immediate-mode bank (B) driven by hand.
module tb_avalon_pio_bank;

    localparam int OP_IDLE  = 0;
    localparam int OP_WRITE = 1;
    localparam int OP_READ  = 2;

    localparam logic [63:0] O0 = 64'h00A0_00A0_00A0_00A0;
    localparam logic [63:0] O1 = 64'h00A0_00A0_1234_00A0;
    localparam logic [63:0] O2 = 64'h00A0_00A0_12C0_00A0;
    localparam logic [63:0] O3 = 64'h00A0_0002_12C0_00A0;
    localparam logic [63:0] O4 = 64'h00A0_0003_12C0_00A0;
    localparam logic [63:0] O5 = 64'h0033_0003_12C0_0011;

    typedef struct {
        int          op;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic        fs;
        logic [63:0] exp_out;
        logic        exp_pulse;
        logic [31:0] exp_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;

    logic [3:0]  addr_a;
    logic        cs_a, wn_a, fs_a;
    logic [31:0] wd_a, rd_a;
    logic [63:0] out_a;
    logic        pulse_a;

    logic [4:0]  addr_b;
    logic        cs_b, wn_b, fs_b;
    logic [31:0] wd_b, rd_b;
    logic [63:0] out_b;
    logic        pulse_b;
    logic        pulse_b_seen = 1'b0;

    int tests  = 0;
    int failed = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    avalon_pio_bank #(
        .CHANNELS(4), .WIDTH(16), .RESET_VALUE(16'h00A0), .COMMIT_MODE(1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .address(addr_a), .chipselect(cs_a),
        .write_n(wn_a), .writedata(wd_a), .readdata(rd_a),
        .frame_sync(fs_a), .out_port(out_a), .commit_pulse(pulse_a)
    );

    // Wider address so that channel field value 4 is reachable.
    avalon_pio_bank #(
        .CHANNELS(4), .WIDTH(16), .RESET_VALUE(16'h0000), .COMMIT_MODE(0),
        .ADDR_W(5)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .address(addr_b), .chipselect(cs_b),
        .write_n(wn_b), .writedata(wd_b), .readdata(rd_b),
        .frame_sync(fs_b), .out_port(out_b), .commit_pulse(pulse_b)
    );

    always @(posedge clk) begin
        if (reset_n === 1'b1 && pulse_b === 1'b1) pulse_b_seen = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int op, input logic [4:0] addr, input logic [31:0] wd,
                                input logic fs, input logic [63:0] eo, input logic ep,
                                input logic [31:0] er);
        vec_t v;
        v.op = op; v.addr = addr; v.wd = wd; v.fs = fs;
        v.exp_out = eo; v.exp_pulse = ep; v.exp_rd = er;
        return v;
    endfunction

    task automatic write_b(input logic [4:0] a, input logic [31:0] d);
        addr_b = a; wd_b = d; cs_b = 1'b1; wn_b = 1'b0;
        step();
        cs_b = 1'b0; wn_b = 1'b1;
    endtask

    task automatic read_b(input logic [4:0] a, output logic [31:0] d);
        addr_b = a; cs_b = 1'b1; wn_b = 1'b1;
        #1;
        d = rd_b;
        cs_b = 1'b0;
    endtask

    initial begin
        logic [31:0] r;

        vecs.push_back(mk(OP_IDLE,  5'd0,  32'h0,    1'b0, O0, 1'b0, 32'h0));
        vecs.push_back(mk(OP_WRITE, 5'd4,  32'h1234, 1'b0, O0, 1'b0, 32'h0));
        vecs.push_back(mk(OP_READ,  5'd5,  32'h0,    1'b0, O0, 1'b0, 32'h0000_00A0));
        vecs.push_back(mk(OP_READ,  5'd4,  32'h0,    1'b0, O0, 1'b0, 32'h8000_1234));
        vecs.push_back(mk(OP_IDLE,  5'd0,  32'h0,    1'b1, O1, 1'b1, 32'h0));
        vecs.push_back(mk(OP_IDLE,  5'd0,  32'h0,    1'b1, O1, 1'b0, 32'h0));
        vecs.push_back(mk(OP_READ,  5'd4,  32'h0,    1'b1, O1, 1'b0, 32'h0000_1234));
        vecs.push_back(mk(OP_WRITE, 5'd4,  32'h1200, 1'b1, O1, 1'b0, 32'h0));
        vecs.push_back(mk(OP_WRITE, 5'd6,  32'h00F0, 1'b1, O1, 1'b0, 32'h0));
        vecs.push_back(mk(OP_WRITE, 5'd7,  32'h0030, 1'b1, O1, 1'b0, 32'h0));
        vecs.push_back(mk(OP_READ,  5'd4,  32'h0,    1'b1, O1, 1'b0, 32'h8000_12C0));
        vecs.push_back(mk(OP_IDLE,  5'd0,  32'h0,    1'b0, O1, 1'b0, 32'h0));
        vecs.push_back(mk(OP_IDLE,  5'd0,  32'h0,    1'b1, O2, 1'b1, 32'h0));
        vecs.push_back(mk(OP_IDLE,  5'd0,  32'h0,    1'b1, O2, 1'b0, 32'h0));
        vecs.push_back(mk(OP_WRITE, 5'd8,  32'h0002, 1'b0, O2, 1'b0, 32'h0));
        vecs.push_back(mk(OP_WRITE, 5'd8,  32'h0003, 1'b1, O3, 1'b1, 32'h0));
        vecs.push_back(mk(OP_READ,  5'd8,  32'h0,    1'b1, O3, 1'b0, 32'h8000_0003));
        vecs.push_back(mk(OP_READ,  5'd9,  32'h0,    1'b1, O3, 1'b0, 32'h0000_0002));
        vecs.push_back(mk(OP_IDLE,  5'd0,  32'h0,    1'b0, O3, 1'b0, 32'h0));
        vecs.push_back(mk(OP_IDLE,  5'd0,  32'h0,    1'b1, O4, 1'b1, 32'h0));
        vecs.push_back(mk(OP_READ,  5'd8,  32'h0,    1'b1, O4, 1'b0, 32'h0000_0003));
        vecs.push_back(mk(OP_WRITE, 5'd0,  32'h0011, 1'b0, O4, 1'b0, 32'h0));
        vecs.push_back(mk(OP_WRITE, 5'd12, 32'h0033, 1'b0, O4, 1'b0, 32'h0));
        vecs.push_back(mk(OP_IDLE,  5'd0,  32'h0,    1'b1, O5, 1'b1, 32'h0));
        vecs.push_back(mk(OP_IDLE,  5'd0,  32'h0,    1'b1, O5, 1'b0, 32'h0));
        vecs.push_back(mk(OP_IDLE,  5'd0,  32'h0,    1'b0, O5, 1'b0, 32'h0));
        vecs.push_back(mk(OP_IDLE,  5'd0,  32'h0,    1'b1, O5, 1'b0, 32'h0));
        vecs.push_back(mk(OP_WRITE, 5'd5,  32'hFFFF, 1'b0, O5, 1'b0, 32'h0));
        vecs.push_back(mk(OP_READ,  5'd5,  32'h0,    1'b0, O5, 1'b0, 32'h0000_12C0));
        vecs.push_back(mk(OP_READ,  5'd4,  32'h0,    1'b0, O5, 1'b0, 32'h0000_12C0));
        vecs.push_back(mk(OP_READ,  5'd0,  32'h0,    1'b0, O5, 1'b0, 32'h0000_0011));
        vecs.push_back(mk(OP_READ,  5'd13, 32'h0,    1'b0, O5, 1'b0, 32'h0000_0033));

        reset_n = 1'b0;
        addr_a = '0; cs_a = 1'b0; wn_a = 1'b1; wd_a = '0; fs_a = 1'b1;
        addr_b = '0; cs_b = 1'b0; wn_b = 1'b1; wd_b = '0; fs_b = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        step();
        check("reset_out_port", out_a, O0);
        check("reset_no_pulse", {63'd0, pulse_a}, 64'd0);
        addr_a = 4'd7; cs_a = 1'b1; #1;
        check("reset_read_ch1_clear", {32'd0, rd_a}, 64'h0000_00A0);
        addr_a = 4'd15; #1;
        check("reset_read_ch3_clear", {32'd0, rd_a}, 64'h0000_00A0);
        cs_a = 1'b0;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            fs_a = v.fs;
            if (v.op == OP_READ) begin
                addr_a = v.addr[3:0]; cs_a = 1'b1; wn_a = 1'b1;
                #1;
                check($sformatf("vec%0d_read", i), {32'd0, rd_a}, {32'd0, v.exp_rd});
                cs_a = 1'b0;
            end else begin
                if (v.op == OP_WRITE) begin
                    addr_a = v.addr[3:0]; wd_a = v.wd; cs_a = 1'b1; wn_a = 1'b0;
                end
                step();
                cs_a = 1'b0; wn_a = 1'b1;
                check($sformatf("vec%0d_out", i), out_a, v.exp_out);
                check($sformatf("vec%0d_pulse", i), {63'd0, pulse_a}, {63'd0, v.exp_pulse});
            end
        end

        // Mid-frame reset discards a pending update.
        fs_a = 1'b0;
        addr_a = 4'd0; wd_a = 32'h7777; cs_a = 1'b1; wn_a = 1'b0;
        step();
        cs_a = 1'b0; wn_a = 1'b1;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        check("midreset_out", out_a, O0);
        fs_a = 1'b1;
        step();
        check("midreset_tick_out", out_a, O0);
        check("midreset_tick_pulse", {63'd0, pulse_a}, 64'd0);
        addr_a = 4'd0; cs_a = 1'b1; #1;
        check("midreset_shadow", {32'd0, rd_a}, 64'h0000_00A0);
        cs_a = 1'b0;

        // Immediate mode bank.
        write_b(5'd0, 32'h5555);
        check("imm_out_ch0", out_b, 64'h0000_0000_0000_5555);
        read_b(5'd0, r);
        check("imm_shadow_no_pending", {32'd0, r}, 64'h0000_5555);
        write_b(5'd12, 32'h0001);
        check("imm_out_ch3", out_b, 64'h0001_0000_0000_5555);
        write_b(5'd16, 32'hFFFF);
        check("imm_oor_write", out_b, 64'h0001_0000_0000_5555);
        read_b(5'd16, r);
        check("imm_oor_read", {32'd0, r}, 64'd0);
        write_b(5'd2, 32'h000F);
        check("imm_set", out_b, 64'h0001_0000_0000_555F);
        fs_b = 1'b1; step(); fs_b = 1'b0; step(); fs_b = 1'b1; step();
        check("imm_tick_no_change", out_b, 64'h0001_0000_0000_555F);
        check("imm_never_pulse", {63'd0, pulse_b_seen}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
